// File: rtl/prog_loader.sv
// prog_loader: byte-serial program image loader.
// Accepts a framed image (16-bit word count, little-endian words, XOR checksum)
// over a valid/ready byte stream. Each 4-byte group becomes one 32-bit word that
// is written to program memory from address 0 upward. The core is held in reset
// until a complete image has been received and its checksum verified.
module prog_loader #(
    parameter int ADDR_WIDTH   = 8,
    parameter bit CHECK_OPCODE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    // Word index is one bit wider than the address so a full-memory image
    // (N == 2**ADDR_WIDTH) can be counted without wrapping.
    localparam int          IDX_W    = ADDR_WIDTH + 1;
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    localparam logic [1:0] ERR_LEN = 2'b01;
    localparam logic [1:0] ERR_OPC = 2'b10;
    localparam logic [1:0] ERR_CHK = 2'b11;

    state_t                state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [15:0]           len_q, len_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [1:0]            lane_q, lane_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            xor_q, xor_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  core_hold_q, core_hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [1:0]            err_code_q, err_code_d;

    logic                  accept;
    logic [15:0]           n_word;
    logic [31:0]           word;
    logic [16:0]           idx_next;

    // Opcode field values 0 and 25..31 are not assigned to any instruction.
    function automatic logic opcode_reserved(input logic [4:0] op);
        return (op == 5'd0) || (op >= 5'd25);
    endfunction

    assign accept   = in_valid && in_ready_q;
    assign n_word   = {in_data, len_lo_q};
    // Bytes arrive lane 0 first and shift down, so after three bytes asm_q
    // holds {lane2, lane1, lane0} and the fourth byte completes the top lane.
    assign word     = {in_data, asm_q};
    assign idx_next = 17'(idx_q) + 17'd1;

    // Next-state and next-output computation for the load FSM.
    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        asm_d       = asm_q;
        xor_d       = xor_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        core_hold_d = core_hold_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d     = S_LEN0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_code_d  = 2'b00;
                    core_hold_d = 1'b1;
                    idx_d       = '0;
                    lane_d      = 2'b00;
                    xor_d       = 8'h00;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_lo_d = in_data;
                    xor_d    = xor_q ^ in_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d = n_word;
                    xor_d = xor_q ^ in_data;
                    if ({1'b0, n_word} > CAPACITY) begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_LEN;
                    end else if (n_word == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    xor_d = xor_q ^ in_data;
                    if (lane_q != 2'd3) begin
                        asm_d  = {in_data, asm_q[23:8]};
                        lane_d = lane_q + 2'd1;
                    end else begin
                        lane_d = 2'd0;
                        if (CHECK_OPCODE && opcode_reserved(word[4:0])) begin
                            state_d    = S_ERR;
                            error_d    = 1'b1;
                            err_code_d = ERR_OPC;
                        end else begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = idx_q[ADDR_WIDTH-1:0];
                            mem_wdata_d = word;
                            idx_d       = idx_next[IDX_W-1:0];
                            if (idx_next == {1'b0, len_q}) begin
                                state_d = S_CHK;
                            end
                        end
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    if (in_data == xor_q) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        core_hold_d = 1'b0;
                    end else begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_CHK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                     (state_d == S_DATA) || (state_d == S_CHK);
        in_ready_d = busy_d;
    end

    // State and registered outputs, all returned to idle values by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_lo_q    <= 8'h00;
            len_q       <= 16'h0000;
            idx_q       <= '0;
            lane_q      <= 2'b00;
            asm_q       <= 24'h000000;
            xor_q       <= 8'h00;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            core_hold_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            asm_q       <= asm_d;
            xor_q       <= xor_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_hold_q <= core_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = core_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader (ADDR_WIDTH=8, CHECK_OPCODE=1).
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int tests = 0;
    int fails = 0;

    // Write log filled by the memory-side monitor.
    int          wr_n = 0;
    logic [7:0]  wr_addr [16];
    logic [31:0] wr_data [16];

    prog_loader #(.ADDR_WIDTH(8), .CHECK_OPCODE(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_n < 16) begin
                wr_addr[wr_n] = mem_addr;
                wr_data[wr_n] = mem_wdata;
            end
            wr_n = wr_n + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1 for byte %h", in_ready, b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk); #1;
        tests++; if (in_ready  !== 1'b0)  begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        tests++; if (mem_we    !== 1'b0)  begin fails++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        tests++; if (mem_addr  !== 8'h00) begin fails++; $display("FAIL rst_mem_addr: got %h want 00", mem_addr); end
        tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        tests++; if (core_hold !== 1'b1)  begin fails++; $display("FAIL rst_core_hold: got %b want 1", core_hold); end
        tests++; if (busy      !== 1'b0)  begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests++; if (done      !== 1'b0)  begin fails++; $display("FAIL rst_done: got %b want 0", done); end
        tests++; if (error     !== 1'b0)  begin fails++; $display("FAIL rst_error: got %b want 0", error); end
        tests++; if (err_code  !== 2'b00) begin fails++; $display("FAIL rst_err_code: got %b want 00", err_code); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        logic [7:0] f [7];
        f = '{8'h01, 8'h00, 8'h86, 8'h56, 8'h34, 8'h12, 8'hF7};
        wr_n = 0;
        pulse_start();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
        for (int i = 0; i < 7; i++) send_byte(f[i]);
        @(negedge clk);
        tests++; if (wr_n !== 1) begin fails++; $display("FAIL single_wr_count: got %0d want 1", wr_n); end
        tests++; if (wr_addr[0] !== 8'h00) begin fails++; $display("FAIL single_wr_addr: got %h want 00", wr_addr[0]); end
        tests++; if (wr_data[0] !== 32'h12345686) begin fails++; $display("FAIL single_wr_data: got %h want 12345686", wr_data[0]); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL single_done: got %b want 1", done); end
        tests++; if (core_hold !== 1'b0) begin fails++; $display("FAIL single_core_hold: got %b want 0", core_hold); end
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL single_error: got %b want 0", error); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL single_in_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] f [7];
        f = '{8'h01, 8'h00, 8'h86, 8'h56, 8'h34, 8'h12, 8'h00};
        repeat (3) @(posedge clk); #1;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL persist_done: got %b want 1", done); end
        wr_n = 0;
        pulse_start();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL start_clears_done: got %b want 0", done); end
        tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL start_sets_hold: got %b want 1", core_hold); end
        for (int i = 0; i < 7; i++) send_byte(f[i]);
        @(negedge clk);
        tests++; if (wr_n !== 1) begin fails++; $display("FAIL badchk_wr_count: got %0d want 1", wr_n); end
        tests++; if (wr_data[0] !== 32'h12345686) begin fails++; $display("FAIL badchk_wr_data: got %h want 12345686", wr_data[0]); end
        tests++; if (error !== 1'b1) begin fails++; $display("FAIL badchk_error: got %b want 1", error); end
        tests++; if (err_code !== 2'b11) begin fails++; $display("FAIL badchk_err_code: got %b want 11", err_code); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL badchk_done: got %b want 0", done); end
        tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL badchk_core_hold: got %b want 1", core_hold); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL badchk_in_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_reserved_opcode();
        logic [7:0] f [10];
        f = '{8'h02, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00, 8'h00};
        wr_n = 0;
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(f[i]);
        @(negedge clk);
        tests++; if (wr_n !== 1) begin fails++; $display("FAIL opc_wr_count: got %0d want 1", wr_n); end
        tests++; if (wr_addr[0] !== 8'h00) begin fails++; $display("FAIL opc_wr_addr: got %h want 00", wr_addr[0]); end
        tests++; if (wr_data[0] !== 32'h00000006) begin fails++; $display("FAIL opc_wr_data: got %h want 00000006", wr_data[0]); end
        tests++; if (error !== 1'b1) begin fails++; $display("FAIL opc_error: got %b want 1", error); end
        tests++; if (err_code !== 2'b10) begin fails++; $display("FAIL opc_err_code: got %b want 10", err_code); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL opc_in_ready: got %b want 0", in_ready); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL opc_mem_we: got %b want 0", mem_we); end
    endtask

    task automatic test_len_overflow();
        wr_n = 0;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        @(negedge clk);
        tests++; if (error !== 1'b1) begin fails++; $display("FAIL ovf_error: got %b want 1", error); end
        tests++; if (err_code !== 2'b01) begin fails++; $display("FAIL ovf_err_code: got %b want 01", err_code); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ovf_in_ready: got %b want 0", in_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ovf_busy: got %b want 0", busy); end
        repeat (3) @(posedge clk); #1;
        tests++; if (wr_n !== 0) begin fails++; $display("FAIL ovf_wr_count: got %0d want 0", wr_n); end
    endtask

    task automatic test_len_full();
        // N = 256 exactly fills an 8-bit address space and must be accepted.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        @(negedge clk);
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL full_error: got %b want 0", error); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_in_ready: got %b want 1", in_ready); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL full_busy: got %b want 1", busy); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_empty_gapped();
        logic [7:0] f [3];
        f = '{8'h00, 8'h00, 8'h00};
        wr_n = 0;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            send_byte(f[i]);
            repeat (3) @(posedge clk);
            #1;
        end
        tests++; if (wr_n !== 0) begin fails++; $display("FAIL empty_wr_count: got %0d want 0", wr_n); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL empty_done: got %b want 1", done); end
        tests++; if (core_hold !== 1'b0) begin fails++; $display("FAIL empty_core_hold: got %b want 0", core_hold); end
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL empty_error: got %b want 0", error); end
    endtask

    task automatic test_reset_restart();
        logic [7:0] f [11];
        f = '{8'h02, 8'h00, 8'h01, 8'h33, 8'h22, 8'h11, 8'h02, 8'h0C, 8'h0B, 8'h0A, 8'h0C};
        wr_n = 0;
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(f[i]);
        rst = 1'b1;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL midrst_core_hold: got %b want 1", core_hold); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b want 0", done); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL midrst_mem_we: got %b want 0", mem_we); end
        tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL midrst_mem_addr: got %h want 00", mem_addr); end
        tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL midrst_mem_wdata: got %h want 0", mem_wdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        wr_n = 0;
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(f[i]);
        pulse_start();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL restart_ignored_busy: got %b want 1", busy); end
        for (int i = 5; i < 11; i++) send_byte(f[i]);
        @(negedge clk);
        tests++; if (wr_n !== 2) begin fails++; $display("FAIL restart_wr_count: got %0d want 2", wr_n); end
        tests++; if (wr_addr[0] !== 8'h00) begin fails++; $display("FAIL restart_addr0: got %h want 00", wr_addr[0]); end
        tests++; if (wr_data[0] !== 32'h11223301) begin fails++; $display("FAIL restart_data0: got %h want 11223301", wr_data[0]); end
        tests++; if (wr_addr[1] !== 8'h01) begin fails++; $display("FAIL restart_addr1: got %h want 01", wr_addr[1]); end
        tests++; if (wr_data[1] !== 32'h0A0B0C02) begin fails++; $display("FAIL restart_data1: got %h want 0A0B0C02", wr_data[1]); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL restart_done: got %b want 1", done); end
        tests++; if (core_hold !== 1'b0) begin fails++; $display("FAIL restart_core_hold: got %b want 0", core_hold); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_bad_checksum();
        test_reserved_opcode();
        test_len_overflow();
        test_len_full();
        test_empty_gapped();
        test_reset_restart();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
